fu_writeback: RTL and testbench

- Consumer end of the reservation-station issue interface.
- Accepts up to three ALU ops per cycle (lanes 0..2) from the RS and executes each in one cycle.
- Buffers each result in a per-lane result FIFO.
- Drains the FIFOs one result per cycle, round-robin, onto the single wakeup bus that feeds Rename (wakeup_tag/value), the RS, and the ROB (wakeup_rob_index).
- Load/store ops are out of scope; they are never issued to this block.

---
 rtl/rv_ooo_pkg.sv | 28 ++
 rtl/wb_result_fifo.sv | 62 ++++++
 rtl/fu_writeback.sv | 137 +++++++++++++
 tb/tb_fu_writeback.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ooo_pkg.sv
// Shared definitions for the out-of-order core: ALU opcode encoding (also used by the RS)
// and the packed result entry carried from the ALU lanes to the wakeup bus.
package rv_ooo_pkg;

    localparam int NUM_LANES = 3;
    localparam int TAG_W     = 6;
    localparam int ROB_W     = 6;
    localparam int XLEN      = 32;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef struct packed {
        logic             reg_write;
        logic [ROB_W-1:0] rob_index;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } wb_entry_t;

    localparam int ENTRY_W = 1 + ROB_W + TAG_W + XLEN;

endpackage

// File: rtl/wb_result_fifo.sv
// Small per-lane result FIFO with synchronous reset and flush; reset beats flush,
// flush beats push/pop. Storage is not reset, only the pointers and count.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 45,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fu_writeback.sv
// Three-lane single-cycle ALU stage: results are queued per lane and drained
// round-robin, one per cycle, onto the shared wakeup bus (Rename, RS, ROB).
module fu_writeback
    import rv_ooo_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_LANES-1:0]       issue_valid,
    output logic [NUM_LANES-1:0]       issue_ready,
    input  logic [NUM_LANES*3-1:0]     issue_alu_type,
    input  logic [NUM_LANES*XLEN-1:0]  issue_rs1_value,
    input  logic [NUM_LANES*XLEN-1:0]  issue_rs2_value,
    input  logic [NUM_LANES*TAG_W-1:0] issue_phys_rd,
    input  logic [NUM_LANES*ROB_W-1:0] issue_rob_index,
    input  logic [NUM_LANES-1:0]       issue_reg_write,
    output logic                       wakeup_active,
    output logic [TAG_W-1:0]           wakeup_tag,
    output logic [XLEN-1:0]            wakeup_value,
    output logic [ROB_W-1:0]           wakeup_rob_index,
    output logic                       wakeup_reg_write
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [XLEN-1:0] alu_exec(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << shamt;
            ALU_SRA: return $unsigned($signed(a) >>> shamt);
            default: return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
    endfunction

    function automatic logic [1:0] lane_wrap(input logic [1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_LANES) s = s - NUM_LANES;
        return 2'(s);
    endfunction

    wb_entry_t            push_ent [NUM_LANES];
    wb_entry_t            head_ent [NUM_LANES];
    logic [CW-1:0]        lane_cnt [NUM_LANES];
    logic [NUM_LANES-1:0] lane_empty, nonempty, push, pop;

    logic       grant_vld;
    logic [1:0] grant_idx;
    logic [1:0] rr_q, rr_d;
    logic       active_q, active_d;
    wb_entry_t  wb_q, wb_d;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign push_ent[i].reg_write = issue_reg_write[i];
        assign push_ent[i].rob_index = issue_rob_index[ROB_W*i +: ROB_W];
        assign push_ent[i].tag       = issue_phys_rd[TAG_W*i +: TAG_W];
        assign push_ent[i].value     = alu_exec(issue_alu_type[3*i +: 3],
                                                issue_rs1_value[XLEN*i +: XLEN],
                                                issue_rs2_value[XLEN*i +: XLEN]);

        // Ready depends on the registered count only, so a full lane stays
        // not-ready even in a cycle that pops it.
        assign issue_ready[i] = (lane_cnt[i] < CW'(FIFO_DEPTH));
        assign push[i]        = issue_valid[i] & issue_ready[i] & ~flush;
        assign nonempty[i]    = ~lane_empty[i];
        assign pop[i]         = grant_vld & (grant_idx == 2'(i)) & ~flush;

        wb_result_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk_i   (clk),
            .rst_i   (reset),
            .flush_i (flush),
            .push_i  (push[i]),
            .data_i  (push_ent[i]),
            .pop_i   (pop[i]),
            .data_o  (head_ent[i]),
            .empty_o (lane_empty[i]),
            .count_o (lane_cnt[i])
        );
    end

    // Scan from the far end so the lane nearest the RR pointer wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (nonempty[lane_wrap(rr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = lane_wrap(rr_q, k);
            end
        end
    end

    always_comb begin
        active_d = grant_vld;
        rr_d     = rr_q;
        wb_d     = wb_q;
        if (grant_vld) begin
            rr_d = lane_wrap(grant_idx, 1);
            wb_d = head_ent[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            rr_q     <= 2'd0;
            wb_q     <= '0;
        end else if (flush) begin
            active_q <= 1'b0;
            rr_q     <= 2'd0;
        end else begin
            active_q <= active_d;
            rr_q     <= rr_d;
            wb_q     <= wb_d;
        end
    end

    assign wakeup_active    = active_q;
    assign wakeup_tag       = wb_q.tag;
    assign wakeup_value     = wb_q.value;
    assign wakeup_rob_index = wb_q.rob_index;
    assign wakeup_reg_write = wb_q.reg_write;

endmodule

// File: tb/tb_fu_writeback.sv
// Scoreboard bench for fu_writeback: issued ops queue their hand-computed results per lane
// (lane = tag[5:4]); a negedge monitor pops and compares every wakeup broadcast.
module tb_fu_writeback;
    import rv_ooo_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [2:0]  issue_valid, issue_ready, issue_reg_write;
    logic [8:0]  issue_alu_type;
    logic [95:0] issue_rs1_value, issue_rs2_value;
    logic [17:0] issue_phys_rd, issue_rob_index;
    logic        wakeup_active, wakeup_reg_write;
    logic [5:0]  wakeup_tag, wakeup_rob_index;
    logic [31:0] wakeup_value;

    always #5 clk = ~clk;

    fu_writeback #(.FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_alu_type   (issue_alu_type),
        .issue_rs1_value  (issue_rs1_value),
        .issue_rs2_value  (issue_rs2_value),
        .issue_phys_rd    (issue_phys_rd),
        .issue_rob_index  (issue_rob_index),
        .issue_reg_write  (issue_reg_write),
        .wakeup_active    (wakeup_active),
        .wakeup_tag       (wakeup_tag),
        .wakeup_value     (wakeup_value),
        .wakeup_rob_index (wakeup_rob_index),
        .wakeup_reg_write (wakeup_reg_write)
    );

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] value;
        logic [5:0]  rob;
        logic        rw;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    exp_t pend [3];
    int   lane_log[$];
    logic log_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int l, input exp_t e);
        case (l)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic set_lane(input int l, input logic [2:0] typ, input logic [31:0] a,
                            input logic [31:0] b, input logic [5:0] tag,
                            input logic [5:0] rob, input logic rw, input logic [31:0] ev);
        issue_valid[l]            = 1'b1;
        issue_alu_type[3*l +: 3]  = typ;
        issue_rs1_value[32*l +: 32] = a;
        issue_rs2_value[32*l +: 32] = b;
        issue_phys_rd[6*l +: 6]   = tag;
        issue_rob_index[6*l +: 6] = rob;
        issue_reg_write[l]        = rw;
        pend[l] = '{tag, ev, rob, rw};
    endtask

    // One clock edge; ops accepted at this edge move into the scoreboard.
    task automatic step(output logic [2:0] acc);
        acc = issue_valid & issue_ready & {3{~flush}} & {3{~reset}};
        @(posedge clk);
        if (flush || reset) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
        for (int l = 0; l < 3; l++) if (acc[l]) push_exp(l, pend[l]);
        #1;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_active"}, 32'(wakeup_active), 32'h0);
        check({pfx, "_tag"},    32'(wakeup_tag), 32'h0);
        check({pfx, "_value"},  wakeup_value, 32'h0);
        check({pfx, "_rob"},    32'(wakeup_rob_index), 32'h0);
        check({pfx, "_rw"},     32'(wakeup_reg_write), 32'h0);
        check({pfx, "_ready"},  32'(issue_ready), 32'h7);
    endtask

    exp_t mon_e;
    int   mon_lane;
    logic mon_have;

    always @(negedge clk) begin
        if (!reset && wakeup_active) begin
            mon_lane = int'(wakeup_tag[5:4]);
            mon_have = 1'b0;
            case (mon_lane)
                0: if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
                1: if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
                2: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_have = 1'b1; end
                default: mon_have = 1'b0;
            endcase
            if (!mon_have) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got tag 0x%02h value 0x%08h expected no broadcast",
                         wakeup_tag, wakeup_value);
            end else begin
                check("wb_tag",   32'(wakeup_tag), 32'(mon_e.tag));
                check("wb_value", wakeup_value, mon_e.value);
                check("wb_rob",   32'(wakeup_rob_index), 32'(mon_e.rob));
                check("wb_rw",    32'(wakeup_reg_write), 32'(mon_e.rw));
            end
            if (log_en) lane_log.push_back(mon_lane);
        end
    end

    logic [2:0] acc;
    int         s [3];
    int         exp_lane [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        reset = 1'b1; flush = 1'b0;
        issue_valid = '0; issue_alu_type = '0; issue_rs1_value = '0; issue_rs2_value = '0;
        issue_phys_rd = '0; issue_rob_index = '0; issue_reg_write = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst");

        // Single ADD on lane 0: visible only in the cycle after E+1.
        set_lane(0, ALU_ADD, 32'd5, 32'd7, 6'd9, 6'd3, 1'b1, 32'd12);
        step(acc);
        issue_valid = '0;
        @(negedge clk); check("t1_lat_e", 32'(wakeup_active), 32'h0);
        @(negedge clk); check("t1_active", 32'(wakeup_active), 32'h1);
        check("t1_value", wakeup_value, 32'd12);
        @(negedge clk); check("t1_pulse", 32'(wakeup_active), 32'h0);

        // Flush with nothing pending brings the RR pointer back to lane 0.
        flush = 1'b1; step(acc); flush = 1'b0;

        // Three lanes on one edge drain in lane order 0,1,2.
        set_lane(0, ALU_SUB, 32'd1, 32'd2, 6'h01, 6'd1, 1'b1, 32'hFFFF_FFFF);
        set_lane(1, ALU_SRA, 32'h8000_0000, 32'd4, 6'h11, 6'd2, 1'b1, 32'hF800_0000);
        set_lane(2, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 6'h21, 6'd4, 1'b0, 32'd1);
        step(acc);
        issue_valid = '0;
        @(negedge clk); check("t2_lat", 32'(wakeup_active), 32'h0);
        @(negedge clk); check("t2_first", wakeup_value, 32'hFFFF_FFFF);
        @(negedge clk); check("t2_second", wakeup_value, 32'hF800_0000);
        @(negedge clk); check("t2_third", wakeup_value, 32'd1);
        check("t2_third_active", 32'(wakeup_active), 32'h1);
        @(negedge clk); check("t2_done", 32'(wakeup_active), 32'h0);

        // Remaining ALU ops, including shift-amount masking to rs2[4:0].
        set_lane(0, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 6'h02, 6'd5, 1'b1, 32'h00F0_1234);
        set_lane(1, ALU_OR,  32'hF000_0000, 32'h0000_000F, 6'h12, 6'd6, 1'b1, 32'hF000_000F);
        set_lane(2, ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 6'h22, 6'd7, 1'b1, 32'hF0F0_0F0F);
        step(acc);
        issue_valid = '0;
        repeat (4) @(negedge clk);
        set_lane(0, ALU_SLL, 32'd1, 32'h0000_003F, 6'h03, 6'd8, 1'b1, 32'h8000_0000);
        set_lane(1, ALU_SLT, 32'd5, 32'hFFFF_FFFD, 6'h13, 6'd9, 1'b1, 32'd0);
        set_lane(2, ALU_SRA, 32'h7FFF_FFFF, 32'h0000_0021, 6'h23, 6'd10, 1'b1, 32'h3FFF_FFFF);
        step(acc);
        issue_valid = '0;
        repeat (5) @(negedge clk);

        // Backpressure: all lanes stream; after E1 counts are (1,2,2) so only lane 0 is ready.
        log_en = 1'b1;
        s = '{0, 0, 0};
        for (int c = 0; c < 10; c++) begin
            for (int l = 0; l < 3; l++)
                set_lane(l, ALU_ADD, 32'(s[l]), 32'(l * 100), 6'(l * 16 + s[l]),
                         6'(l * 16 + s[l]), 1'b1, 32'(s[l] + l * 100));
            step(acc);
            for (int l = 0; l < 3; l++) if (acc[l]) s[l]++;
            if (c == 1) check("t3_ready_after_e1", 32'(issue_ready), 32'h1);
        end
        issue_valid = '0;
        repeat (14) @(negedge clk);
        #2;
        log_en = 1'b0;
        check("t3_log_len_ok", 32'(lane_log.size() >= 6), 32'h1);
        for (int k = 0; k < 6; k++)
            if (k < lane_log.size()) check("t3_rotation", 32'(lane_log[k]), 32'(exp_lane[k]));
        check("t3_drained", 32'(q0.size() + q1.size() + q2.size()), 32'h0);

        // Lane 0 only, one op per cycle: pushes and pops overlap, ready never drops.
        for (int c = 0; c < 10; c++) begin
            set_lane(0, ALU_XOR, 32'(c), 32'hA5A5_0000, 6'(c), 6'(c + 20), 1'b1,
                     32'hA5A5_0000 | 32'(c));
            step(acc);
            check("t4_ready", 32'(issue_ready), 32'h7);
        end
        issue_valid = '0;
        repeat (4) @(negedge clk);
        #2;
        check("t4_drained", 32'(q0.size()), 32'h0);

        // Flush: pointer is 1, so edge B pops lane 2 leaving lane0=2, lane2=1.
        set_lane(0, ALU_ADD, 32'd1, 32'd1, 6'h04, 6'd11, 1'b1, 32'd2);
        set_lane(2, ALU_ADD, 32'd2, 32'd2, 6'h24, 6'd12, 1'b1, 32'd4);
        step(acc);
        set_lane(0, ALU_ADD, 32'd3, 32'd3, 6'h05, 6'd13, 1'b1, 32'd6);
        set_lane(2, ALU_ADD, 32'd4, 32'd4, 6'h25, 6'd14, 1'b1, 32'd8);
        step(acc);
        issue_valid = '0;
        flush = 1'b1;
        set_lane(1, ALU_ADD, 32'd9, 32'd9, 6'h14, 6'd15, 1'b1, 32'd18);
        step(acc);
        flush = 1'b0;
        issue_valid = '0;
        check("t5_active", 32'(wakeup_active), 32'h0);
        check("t5_ready", 32'(issue_ready), 32'h7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_quiet", 32'(wakeup_active), 32'h0);
        end

        // Reset mid-burst with four results buffered.
        set_lane(0, ALU_ADD, 32'd10, 32'd1, 6'h06, 6'd16, 1'b1, 32'd11);
        set_lane(1, ALU_ADD, 32'd20, 32'd1, 6'h16, 6'd17, 1'b1, 32'd21);
        set_lane(2, ALU_ADD, 32'd30, 32'd1, 6'h26, 6'd18, 1'b1, 32'd31);
        step(acc);
        issue_valid = '0;
        set_lane(0, ALU_ADD, 32'd40, 32'd1, 6'h07, 6'd19, 1'b1, 32'd41);
        set_lane(1, ALU_ADD, 32'd50, 32'd1, 6'h17, 6'd20, 1'b1, 32'd51);
        step(acc);
        issue_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        step(acc);
        reset = 1'b0;
        check_idle_outputs("t6_rst");
        set_lane(2, ALU_SUB, 32'd10, 32'd3, 6'h27, 6'd21, 1'b1, 32'd7);
        step(acc);
        issue_valid = '0;
        @(negedge clk); check("t6_lat", 32'(wakeup_active), 32'h0);
        @(negedge clk); check("t6_active", 32'(wakeup_active), 32'h1);
        check("t6_tag", 32'(wakeup_tag), 32'h27);
        repeat (3) @(negedge clk);
        #2;
        check("final_drained", 32'(q0.size() + q1.size() + q2.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
